// File: rtl/digit_result_feeder.sv
// digit_result_feeder: argmax over a stream of signed class scores per frame,
// queues the winning digit and presents it to the OLED display controller,
// holding it stable until the controller reports the bitmap as sent.
module digit_result_feeder #(
  parameter int SCORE_W     = 16,
  parameter int NUM_CLASSES = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          score_valid,
  input  logic signed [SCORE_W-1:0]     score_data,
  input  logic                          score_last,
  output logic                          score_ready,
  input  logic                          oled_ready,
  input  logic                          sendDone,
  output logic                          in_data_valid,
  output logic [3:0]                    in_data,
  output logic                          frame_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IN_RUN, IN_DISCARD} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_PRESENT, O_WAIT_LOW} out_state_t;

  in_state_t                 in_state, in_state_next;
  logic [3:0]                beat_idx, beat_idx_next;
  logic signed [SCORE_W-1:0] best_score, best_score_next;
  logic [3:0]                best_idx, best_idx_next;
  logic                      frame_error_next;
  logic                      wr_en;
  logic [3:0]                wr_digit;
  logic                      accept, last_beat;

  logic [3:0]                mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count, count_next;

  out_state_t                out_state, out_state_next;
  logic [3:0]                in_data_next;
  logic                      in_data_valid_next;
  logic                      pop;
  logic                      send_done_d;
  logic                      score_ready_next;

  assign accept     = score_valid & score_ready;
  assign last_beat  = (beat_idx == 4'(NUM_CLASSES - 1));
  assign fifo_count = count;

  // Input side: argmax accumulation, frame-shape checking and discard handling.
  always_comb begin
    in_state_next    = in_state;
    beat_idx_next    = beat_idx;
    best_score_next  = best_score;
    best_idx_next    = best_idx;
    frame_error_next = 1'b0;
    wr_en            = 1'b0;
    wr_digit         = best_idx;
    if (accept) begin
      unique case (in_state)
        IN_RUN: begin
          // Strict compare so ties keep the lower class index.
          if (beat_idx == '0 || score_data > best_score) begin
            best_score_next = score_data;
            best_idx_next   = beat_idx;
          end
          if (score_last) begin
            beat_idx_next = '0;
            if (last_beat) begin
              wr_en    = 1'b1;
              wr_digit = best_idx_next;
            end else begin
              frame_error_next = 1'b1;
            end
          end else if (last_beat) begin
            frame_error_next = 1'b1;
            beat_idx_next    = '0;
            in_state_next    = IN_DISCARD;
          end else begin
            beat_idx_next = beat_idx + 4'd1;
          end
        end
        IN_DISCARD: begin
          if (score_last) in_state_next = IN_RUN;
        end
      endcase
    end
  end

  // Input state and argmax registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state    <= IN_RUN;
      beat_idx    <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      frame_error <= 1'b0;
    end else begin
      in_state    <= in_state_next;
      beat_idx    <= beat_idx_next;
      best_score  <= best_score_next;
      best_idx    <= best_idx_next;
      frame_error <= frame_error_next;
    end
  end

  // Result FIFO storage and pointers; write and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_digit;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // Occupancy bookkeeping and acceptance; a started frame always completes,
  // and since writes only happen at frame end the queue cannot overflow.
  always_comb begin
    count_next       = count + CW'(wr_en) - CW'(pop);
    score_ready_next = (count_next != CW'(FIFO_DEPTH)) ||
                       (beat_idx_next != '0) ||
                       (in_state_next == IN_DISCARD);
  end

  // Registered acceptance flag.
  always_ff @(posedge clk) begin
    if (reset) score_ready <= 1'b0;
    else       score_ready <= score_ready_next;
  end

  // Output FSM: present head, pop on sendDone rising edge, wait for it to drop.
  always_comb begin
    out_state_next     = out_state;
    in_data_next       = in_data;
    in_data_valid_next = in_data_valid;
    pop                = 1'b0;
    unique case (out_state)
      O_IDLE: begin
        if (count != '0 && oled_ready) begin
          out_state_next     = O_PRESENT;
          in_data_next       = mem[rd_ptr];
          in_data_valid_next = 1'b1;
        end
      end
      O_PRESENT: begin
        if (sendDone && !send_done_d) begin
          pop                = 1'b1;
          in_data_valid_next = 1'b0;
          out_state_next     = O_WAIT_LOW;
        end
      end
      O_WAIT_LOW: begin
        if (!sendDone) out_state_next = O_IDLE;
      end
      default: out_state_next = O_IDLE;
    endcase
  end

  // Output FSM state and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state     <= O_IDLE;
      in_data       <= '0;
      in_data_valid <= 1'b0;
      send_done_d   <= 1'b0;
    end else begin
      out_state     <= out_state_next;
      in_data       <= in_data_next;
      in_data_valid <= in_data_valid_next;
      send_done_d   <= sendDone;
    end
  end

endmodule

// File: tb/tb_digit_result_feeder.sv
// Bench for digit_result_feeder: randomized frames against a queue-based
// argmax reference model, plus directed boundary cases.
module tb_digit_result_feeder;

  localparam int SW = 16;
  localparam int NC = 10;
  localparam int FD = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 score_valid = 1'b0;
  logic signed [SW-1:0] score_data = '0;
  logic                 score_last = 1'b0;
  logic                 score_ready;
  logic                 oled_ready = 1'b1;
  logic                 sendDone = 1'b0;
  logic                 in_data_valid;
  logic [3:0]           in_data;
  logic                 frame_error;
  logic [2:0]           fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int exp_q[$];
  logic signed [SW-1:0] frame_sc [0:15];

  digit_result_feeder #(.SCORE_W(SW), .NUM_CLASSES(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .score_valid(score_valid), .score_data(score_data),
    .score_last(score_last), .score_ready(score_ready), .oled_ready(oled_ready),
    .sendDone(sendDone), .in_data_valid(in_data_valid), .in_data(in_data),
    .frame_error(frame_error), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_error === 1'b1) fe_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference argmax: first occurrence of the maximum signed score.
  function automatic int ref_argmax();
    int b = 0;
    for (int k = 1; k < NC; k++) if (frame_sc[k] > frame_sc[b]) b = k;
    return b;
  endfunction

  task automatic fill_random(input int lo, input int hi);
    for (int k = 0; k < 16; k++)
      frame_sc[k] = SW'(lo + int'($urandom_range(hi - lo, 0)));
  endtask

  task automatic make_frame(input int digit);
    fill_random(-1000, 1000);
    frame_sc[digit] = 16'sd2000;
  endtask

  task automatic send_frame(input int n, input int last_at);
    int w;
    if (last_at == NC - 1 && n == NC) exp_q.push_back(ref_argmax());
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (score_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
      if (w >= 300) check("ready_timeout", 0, 1);
      score_valid = 1'b1;
      score_data  = frame_sc[k];
      score_last  = (k == last_at);
      @(negedge clk);
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic present_one(input string tag, input int hold);
    int w = 0;
    while (in_data_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    check({tag, "_valid"}, 32'(in_data_valid), 1);
    check({tag, "_digit"}, 32'(in_data), (exp_q.size() != 0) ? exp_q[0] : 15);
    sendDone = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_held_low"}, 32'(in_data_valid), 0);
    end
    sendDone = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    score_last  = 1'b0;
    sendDone    = 1'b0;
    check("rst_score_ready", 32'(score_ready), 0);
    check("rst_valid", 32'(in_data_valid), 0);
    check("rst_data", 32'(in_data), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_count", 32'(fifo_count), 0);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int f0;
    int w;
    logic signed [SW-1:0] t1 [0:9];
    t1 = '{16'sd5, -16'sd3, 16'sd20, 16'sd7, 16'sd20, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4};

    repeat (2) @(negedge clk);
    do_reset();
    check("post_rst_ready", 32'(score_ready), 1);

    // Directed frame with a tie: lower index wins, latency 2 cycles.
    for (int k = 0; k < NC; k++) frame_sc[k] = t1[k];
    send_frame(NC, NC - 1);
    check("t1_valid_early", 32'(in_data_valid), 0);
    check("t1_count", 32'(fifo_count), 1);
    @(negedge clk);
    check("t1_valid_t2", 32'(in_data_valid), 1);
    check("t1_data", 32'(in_data), 2);
    present_one("t1", 1);

    // All negative, maximum at the last beat, most-negative value at beat 0.
    fill_random(-30000, -2);
    frame_sc[0] = 16'sh8000;
    frame_sc[9] = -16'sd1;
    send_frame(NC, NC - 1);
    check("t2_model", exp_q[0], 9);
    present_one("t2", 1);

    // Early score_last.
    make_frame(4);
    send_frame(7, 6);
    check("t3_short_err", 32'(frame_error), 1);
    check("t3_short_count", 32'(fifo_count), 0);
    @(negedge clk);
    check("t3_short_pulse", 32'(frame_error), 0);

    // Overlong frame: one error, rest discarded.
    f0 = fe_cnt;
    make_frame(6);
    send_frame(12, 11);
    repeat (3) @(negedge clk);
    check("t3_long_err_cnt", fe_cnt - f0, 1);
    check("t3_long_count", 32'(fifo_count), 0);
    check("t3_long_valid", 32'(in_data_valid), 0);
    make_frame(8);
    send_frame(NC, NC - 1);
    present_one("t3_good", 1);

    // Backpressure: fill the queue while the display is not ready.
    oled_ready = 1'b0;
    make_frame(3); send_frame(NC, NC - 1);
    make_frame(1); send_frame(NC, NC - 1);
    make_frame(4); send_frame(NC, NC - 1);
    make_frame(1); send_frame(NC, NC - 1);
    check("t4_ready_low", 32'(score_ready), 0);
    check("t4_count_full", 32'(fifo_count), 4);
    repeat (3) @(negedge clk);
    check("t4_no_present", 32'(in_data_valid), 0);
    make_frame(5);
    fork
      send_frame(NC, NC - 1);
      begin
        oled_ready = 1'b1;
        for (int i = 0; i < 5; i++) present_one("t4", 1);
      end
    join
    repeat (3) @(negedge clk);
    check("t4_drained", 32'(fifo_count), 0);

    // Long sendDone: one pop only; oled_ready drop while presenting is ignored.
    make_frame(7); send_frame(NC, NC - 1);
    make_frame(2); send_frame(NC, NC - 1);
    present_one("t5_hold", 3);
    check("t5_one_pop", 32'(fifo_count), 1);
    w = 0;
    while (in_data_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    oled_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_oled_drop_valid", 32'(in_data_valid), 1);
      check("t5_oled_drop_data", 32'(in_data), 2);
    end
    oled_ready = 1'b1;
    present_one("t5_next", 1);

    // Randomized frames, narrow score range to force frequent ties.
    for (int r = 0; r < 12; r++) begin
      if (r % 2 == 0) fill_random(-4, 3);
      else fill_random(-32768, 32767);
      send_frame(NC, NC - 1);
      present_one("rand", int'($urandom_range(3, 1)));
    end

    // Reset mid-frame at beat 4.
    make_frame(0);
    for (int k = 0; k < 4; k++) begin
      score_valid = 1'b1; score_data = frame_sc[k]; score_last = 1'b0;
      @(negedge clk);
    end
    score_data = frame_sc[4];
    do_reset();
    make_frame(6);
    send_frame(NC, NC - 1);
    present_one("t6_after_mid", 1);

    // Reset while presenting.
    make_frame(9);
    send_frame(NC, NC - 1);
    w = 0;
    while (in_data_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    check("t6_presenting", 32'(in_data_valid), 1);
    do_reset();
    make_frame(3);
    send_frame(NC, NC - 1);
    present_one("t6_after_present", 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
